// File: rtl/deser_lanes.sv
// Multi-lane IDDR deserializer that hunts for the frame word at either bit phase and emits one word per lane per frame.
// Optional build macro DESER_PATTERN_CHECK_EN adds test_pattern / pat_err_cnt for ADC test-pattern checking.
module deser_lanes #(
  parameter int                   NUM_LANES     = 2,
  parameter int                   WORD_BITS     = 8,
  parameter logic [WORD_BITS-1:0] FRAME_PATTERN = 8'hF0,
  parameter int                   MAX_MISS      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_LANES-1:0]           d_rise,
  input  logic [NUM_LANES-1:0]           d_fall,
  input  logic                           fr_rise,
  input  logic                           fr_fall,
  input  logic                           resync,
  output logic [NUM_LANES*WORD_BITS-1:0] q,
  output logic                           q_valid,
  output logic                           locked,
  output logic                           slip,
  output logic [7:0]                     miss_cnt
`ifdef DESER_PATTERN_CHECK_EN
  ,
  input  logic [WORD_BITS-1:0]           test_pattern,
  output logic [15:0]                    pat_err_cnt
`endif
);

  localparam int WPC = WORD_BITS / 2;
  localparam int CW  = (WPC > 1) ? $clog2(WPC) : 1;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t                                 state, state_nx;
  logic [WORD_BITS:0]                     fr_sr_p0;
  logic [NUM_LANES-1:0][WORD_BITS:0]      lane_sr_p0;
  logic [CW-1:0]                          cnt, cnt_nx;
  logic [3:0]                             consec, consec_nx;
  logic                                   slip_nx, emit, miss_hit;
  logic                                   even_match, odd_match, frame_ok;
  logic [NUM_LANES*WORD_BITS-1:0]         q_nx;

  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] a);
    return (a == CW'(WPC - 1)) ? '0 : a + CW'(1);
  endfunction

  function automatic logic [WORD_BITS-1:0] win(input logic [WORD_BITS:0] sr, input logic odd);
    return odd ? sr[WORD_BITS:1] : sr[WORD_BITS-1:0];
  endfunction

  assign even_match = (fr_sr_p0[WORD_BITS-1:0] == FRAME_PATTERN);
  assign odd_match  = (fr_sr_p0[WORD_BITS:1]   == FRAME_PATTERN);
  assign frame_ok   = (win(fr_sr_p0, slip)     == FRAME_PATTERN);

  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    slip_nx   = slip;
    cnt_nx    = cnt;
    consec_nx = consec;
    emit      = 1'b0;
    miss_hit  = 1'b0;
    case (state)
      SEARCH: begin
        if (even_match) begin
          state_nx = LOCKED;
          slip_nx  = 1'b0;
          cnt_nx   = CW'(1);
          emit     = 1'b1;
        end else if (odd_match) begin
          state_nx = LOCKED;
          slip_nx  = 1'b1;
          cnt_nx   = CW'(1);
          emit     = 1'b1;
        end
      end
      LOCKED: begin
        cnt_nx = wrap_inc(cnt);
        if (cnt == '0) begin
          if (frame_ok) begin
            emit      = 1'b1;
            consec_nx = '0;
          end else begin
            miss_hit = 1'b1;
            if (consec == 4'(MAX_MISS - 1)) begin
              state_nx  = SEARCH;
              consec_nx = '0;
            end else begin
              consec_nx = consec + 4'd1;
            end
          end
        end
      end
      default: state_nx = SEARCH;
    endcase
    // resync wins over any boundary or match decided above
    if (resync) begin
      state_nx  = SEARCH;
      slip_nx   = slip;
      cnt_nx    = cnt;
      consec_nx = '0;
      emit      = 1'b0;
      miss_hit  = 1'b0;
    end
  end

  always_comb begin
    q_nx = '0;
    for (int i = 0; i < NUM_LANES; i++)
      q_nx[i*WORD_BITS +: WORD_BITS] = win(lane_sr_p0[i], slip_nx);
  end

  // p0: bit-pair shift registers; output stage: word register and control
  always_ff @(posedge clk) begin
    if (rst) begin
      fr_sr_p0   <= '0;
      lane_sr_p0 <= '0;
      q          <= '0;
      q_valid    <= 1'b0;
      locked     <= 1'b0;
      slip       <= 1'b0;
      cnt        <= '0;
      consec     <= '0;
      miss_cnt   <= '0;
    end else begin
      fr_sr_p0 <= {fr_sr_p0[WORD_BITS-2:0], fr_rise, fr_fall};
      for (int i = 0; i < NUM_LANES; i++)
        lane_sr_p0[i] <= {lane_sr_p0[i][WORD_BITS-2:0], d_rise[i], d_fall[i]};
      q_valid <= emit;
      if (emit) q <= q_nx;
      locked  <= (state_nx == LOCKED);
      slip    <= slip_nx;
      cnt     <= cnt_nx;
      consec  <= consec_nx;
      if (miss_hit) miss_cnt <= sat_inc8(miss_cnt);
    end
  end

`ifdef DESER_PATTERN_CHECK_EN
  logic [15:0] n_err;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    n_err = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (q_nx[i*WORD_BITS +: WORD_BITS] != test_pattern) n_err = n_err + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || resync) pat_err_cnt <= '0;
    else if (emit)     pat_err_cnt <= sat_add16(pat_err_cnt, n_err);
  end
`endif

endmodule

// File: tb/tb_deser_lanes.sv
// Randomized scoreboard bench for deser_lanes: a bit-history reference model predicts every emitted word and its edge.
module tb_deser_lanes;
  localparam int NL = 2;
  localparam int W = 8;
  localparam int WPC = W / 2;
  localparam int MAXM = 4;
  localparam int LW = NL * W;
  localparam logic [W-1:0] PAT = 8'hF0;

  logic clk = 1'b0;
  logic rst, resync;
  logic [NL-1:0] d_rise, d_fall;
  logic fr_rise, fr_fall;
  logic [LW-1:0] q;
  logic q_valid, locked, slip;
  logic [7:0] miss_cnt;
`ifdef DESER_PATTERN_CHECK_EN
  logic [W-1:0] test_pattern = 8'hA5;
  logic [15:0] pat_err_cnt;
`endif

  deser_lanes #(.NUM_LANES(NL), .WORD_BITS(W), .FRAME_PATTERN(PAT), .MAX_MISS(MAXM)) dut (
    .clk(clk), .rst(rst), .d_rise(d_rise), .d_fall(d_fall),
    .fr_rise(fr_rise), .fr_fall(fr_fall), .resync(resync),
    .q(q), .q_valid(q_valid), .locked(locked), .slip(slip), .miss_cnt(miss_cnt)
`ifdef DESER_PATTERN_CHECK_EN
    , .test_pattern(test_pattern), .pat_err_cnt(pat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [NL:0] col_t;  // bit NL is the frame lane
  typedef struct { int unsigned cyc; logic [LW-1:0] q; } exp_t;

  col_t bq[$];     // bits still to be transmitted, one element per bit time
  col_t hist[$];   // bits received since the last reset
  exp_t sbq[$];
  int checks = 0, errors = 0;
  bit chk_en = 0;

  bit m_locked, m_slip;
  int m_miss, m_consec;
  int unsigned m_next_bnd;
  logic [LW-1:0] m_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // W-bit word of a lane whose newest bit is hist[last]; bits before reset read as 0
  function automatic logic [W-1:0] word_at(int lane, int last);
    logic [W-1:0] w;
    int idx;
    for (int k = 0; k < W; k++) begin
      idx = last - (W - 1) + k;
      w[W-1-k] = (idx >= 0 && idx < hist.size()) ? hist[idx][lane] : 1'b0;
    end
    return w;
  endfunction

  function automatic void model_edge(int unsigned e);
    int n;
    bit emit;
    if (rst) begin
      hist.delete();
      m_locked = 0; m_slip = 0; m_miss = 0; m_consec = 0; m_q = '0;
      return;
    end
    n = hist.size();
    emit = 0;
    if (resync) begin
      m_locked = 0;
      m_consec = 0;
    end else if (!m_locked) begin
      if (word_at(NL, n - 1) == PAT) begin
        m_slip = 0; m_locked = 1; m_next_bnd = e + WPC; emit = 1;
      end else if (word_at(NL, n - 2) == PAT) begin
        m_slip = 1; m_locked = 1; m_next_bnd = e + WPC; emit = 1;
      end
    end else if (e == m_next_bnd) begin
      m_next_bnd += WPC;
      if (word_at(NL, n - 1 - int'(m_slip)) == PAT) begin
        emit = 1;
        m_consec = 0;
      end else begin
        if (m_miss < 255) m_miss++;
        m_consec++;
        if (m_consec == MAXM) begin
          m_locked = 0;
          m_consec = 0;
        end
      end
    end
    if (emit) begin
      for (int i = 0; i < NL; i++) m_q[i*W +: W] = word_at(i, n - 1 - int'(m_slip));
      sbq.push_back(exp_t'{cyc: e, q: m_q});
    end
  endfunction

  task automatic push_word(input logic [W-1:0] fw, input logic [LW-1:0] lw);
    col_t c;
    for (int k = W - 1; k >= 0; k--) begin
      c[NL] = fw[k];
      for (int i = 0; i < NL; i++) c[i] = lw[i*W + k];
      bq.push_back(c);
    end
  endtask

  // Drive the bit pair for the upcoming edge, then wait for the following negedge
  task automatic step();
    col_t b0, b1;
    b0 = (bq.size() > 0) ? bq.pop_front() : '0;
    b1 = (bq.size() > 0) ? bq.pop_front() : '0;
    model_edge(cyc);
    fr_rise = b0[NL];
    fr_fall = b1[NL];
    d_rise  = b0[NL-1:0];
    d_fall  = b1[NL-1:0];
    if (!rst) begin
      hist.push_back(b0);
      hist.push_back(b1);
    end
    @(negedge clk);
  endtask

  task automatic run_q();
    while (bq.size() > 0) step();
  endtask

  // Monitor: pops the scoreboard on every q_valid and tracks status outputs every cycle
  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        if (q_valid === 1'b1) begin
          if (sbq.size() > 0) begin
            it = sbq.pop_front();
            chk("q_word", q, it.q);
            chk("q_valid_edge", cyc - 1, it.cyc);
          end else begin
            chk("q_valid_spurious", q_valid, 1'b0);
          end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cyc - 1) begin
          it = sbq.pop_front();
          chk("q_valid_missing", q_valid, 1'b1);
        end
        chk("q_hold", q, m_q);
        chk("locked", locked, m_locked);
        chk("slip", slip, m_slip);
        chk("miss_cnt", miss_cnt, m_miss);
      end
    end
  end

  initial begin
    bit found;
    logic [W-1:0] fw;
    logic [LW-1:0] lw;
    rst = 1; resync = 0; d_rise = '0; d_fall = '0; fr_rise = 0; fr_fall = 0;
    step();
    chk_en = 1;
    repeat (2) step();
    chk("rst_q", q, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_locked", locked, 0);
    rst = 0;

    // Even-phase lock with fixed lane words
    repeat (12) push_word(PAT, {8'h3C, 8'hA5});
    run_q();
    chk("even_locked", locked, 1);
    chk("even_slip", slip, 0);
    chk("even_q", q, 16'h3CA5);

    repeat (20) push_word(PAT, LW'($urandom()));
    run_q();

    // Transient misses keep lock
    repeat (3) push_word(8'hFF, LW'($urandom()));
    repeat (6) push_word(PAT, LW'($urandom()));
    run_q();
    chk("transient_locked", locked, 1);
    chk("transient_miss", miss_cnt, 3);

    // MAX_MISS consecutive misses force re-search, then relock
    repeat (4) push_word(8'hFF, LW'($urandom()));
    repeat (8) push_word(PAT, {8'h3C, 8'hA5});
    run_q();
    chk("relock_locked", locked, 1);
    chk("relock_miss", miss_cnt, 7);
    chk("relock_q", q, 16'h3CA5);

    // resync on a boundary edge
    repeat (8) push_word(PAT, LW'($urandom()));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_locked && cyc == m_next_bnd) found = 1;
      else step();
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL resync_boundary_wait: no boundary within budget");
    end
    resync = 1;
    step();
    resync = 0;
    chk("resync_q_valid", q_valid, 0);
    chk("resync_locked", locked, 0);
    chk("resync_miss_kept", miss_cnt, 7);
    run_q();

    // rst mid-word
    repeat (4) push_word(PAT, LW'($urandom()));
    repeat (5) step();
    rst = 1;
    step();
    rst = 0;
    bq.delete();
    chk("midrst_q", q, 0);
    chk("midrst_q_valid", q_valid, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_miss", miss_cnt, 0);
    chk("midrst_slip", slip, 0);

    // Odd-phase lock: stream delayed by one bit
    bq.push_back('0);
    repeat (12) push_word(PAT, {8'h3C, 8'hA5});
    run_q();
    chk("odd_locked", locked, 1);
    chk("odd_slip", slip, 1);
    chk("odd_q", q, 16'h3CA5);
    chk("odd_miss", miss_cnt, 0);

    // Random frames, data and occasional resync
    for (int wdx = 0; wdx < 150; wdx++) begin
      fw = ($urandom_range(0, 3) == 0) ? W'($urandom()) : PAT;
      lw = LW'($urandom());
      push_word(fw, lw);
    end
    while (bq.size() > 0) begin
      resync = ($urandom_range(0, 63) == 0);
      step();
    end
    resync = 0;
    repeat (8) step();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
